// File: rtl/dct_pkg.sv
// dct_pkg: shared constants for the DCT multiply-accumulate datapath.
//   COS_W / IDX_W : coefficient and index widths
//   SHIFT / ROUND : final scaling (64*64*... -> coefficient) with round-half-up
//   COS_TAB       : C[k][n] = round(64*c(k)*cos((2n+1)k*pi/16)), c(0)=1/sqrt(2)
package dct_pkg;
  localparam int COS_W = 8;
  localparam int IDX_W = 3;
  localparam int SHIFT = 14;
  localparam int ROUND = 1 << 13;

  localparam logic signed [COS_W-1:0] COS_TAB [8][8] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
  };
endpackage

// File: rtl/dct_cos_rom.sv
// dct_cos_rom: combinational cosine coefficient lookup.
//   k : frequency index (u or v)
//   n : spatial index (x or y)
//   c : signed C[k][n]
module dct_cos_rom
  import dct_pkg::*;
(
  input  logic [IDX_W-1:0]        k,
  input  logic [IDX_W-1:0]        n,
  output logic signed [COS_W-1:0] c
);
  assign c = COS_TAB[k][n];
endmodule

// File: rtl/dct_mac_unit.sv
// dct_mac_unit: 4-stage pixel x C(u,x) x C(v,y) multiply-accumulate that emits
// one rounded 2-D DCT coefficient every 64 accepted terms.
//   clock, reset (async, active low)
//   active_MAC      : term strobe; pixel_data/u/v/x/y sampled with it
//   reset_MAC       : synchronous clear of acc, term counter and pipeline
//   dct_out         : signed F(u,v), held until the next out_valid
//   out_valid       : one-cycle pulse when dct_out/out_index update
//   out_index       : {u,v} tag of the 64th term
//   sat_flag        : sticky clamp indicator
// Optional feature macro: DCT_MAC_SAT_EN (clamp instead of wrap when narrowing).
module dct_mac_unit
  import dct_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int OUT_W = 12,
  parameter int ACC_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 active_MAC,
  input  logic                 reset_MAC,
  input  logic [PIX_W-1:0]     pixel_data,
  input  logic [IDX_W-1:0]     u,
  input  logic [IDX_W-1:0]     v,
  input  logic [IDX_W-1:0]     x,
  input  logic [IDX_W-1:0]     y,
  output logic [OUT_W-1:0]     dct_out,
  output logic                 out_valid,
  output logic [2*IDX_W-1:0]   out_index,
  output logic                 sat_flag
);
  localparam int PIX_S_W = PIX_W + 1;
  localparam int CUV_W   = 2*COS_W - 2;           // |C*C| <= 63*63 fits 14 bits
  localparam int TERM_W  = PIX_S_W + CUV_W - 1;
  localparam int TAG_W   = 2*IDX_W;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(ROUND);

  logic signed [COS_W-1:0]   cx, cy;
  logic signed [PIX_S_W-1:0] pix_ls;

  dct_cos_rom u_rom_ux (.k(u), .n(x), .c(cx));
  dct_cos_rom u_rom_vy (.k(v), .n(y), .c(cy));

  assign pix_ls = $signed({1'b0, pixel_data}) - $signed(PIX_S_W'(1 << (PIX_W-1)));

  // vld_pipe[i] qualifies the data held in stage i (S0..S2)
  logic [2:0]                vld_pipe;
  logic signed [PIX_S_W-1:0] pix_s0, pix_s1;
  logic signed [COS_W-1:0]   cx_s0, cy_s0;
  logic signed [CUV_W-1:0]   cuv_s1;
  logic signed [TERM_W-1:0]  term_s2;
  logic [TAG_W-1:0]          tag_s0, tag_s1, tag_s2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_s0  <= '0;
      cx_s0   <= '0;
      cy_s0   <= '0;
      tag_s0  <= '0;
      pix_s1  <= '0;
      cuv_s1  <= '0;
      tag_s1  <= '0;
      term_s2 <= '0;
      tag_s2  <= '0;
    end else begin
      if (active_MAC) begin
        pix_s0 <= pix_ls;
        cx_s0  <= cx;
        cy_s0  <= cy;
        tag_s0 <= {u, v};
      end
      if (vld_pipe[0]) begin
        pix_s1 <= pix_s0;
        cuv_s1 <= CUV_W'(cx_s0) * CUV_W'(cy_s0);
        tag_s1 <= tag_s0;
      end
      if (vld_pipe[1]) begin
        term_s2 <= TERM_W'(pix_s1) * TERM_W'(cuv_s1);
        tag_s2  <= tag_s1;
      end
    end
  end

  logic signed [ACC_W-1:0] acc, sum, rnd, shifted;
  logic [5:0]              cnt;
  logic [OUT_W-1:0]        res;
  logic                    fire;

  assign sum     = acc + ACC_W'(term_s2);
  assign rnd     = sum + RND;
  assign shifted = rnd >>> SHIFT;
  // reset_MAC wins over the 64th accumulation arriving on the same edge
  assign fire    = vld_pipe[2] && (cnt == 6'd63) && !reset_MAC;

`ifdef DCT_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(64'sd1 <<< (OUT_W-1)));
  logic clamp_hi, clamp_lo;
  assign clamp_hi = shifted > OUT_MAX;
  assign clamp_lo = shifted < OUT_MIN;
  assign res = clamp_hi ? OUT_MAX[OUT_W-1:0] :
               clamp_lo ? OUT_MIN[OUT_W-1:0] : shifted[OUT_W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sat_flag <= 1'b0;
    else if (fire && (clamp_hi || clamp_lo)) sat_flag <= 1'b1;
  end
`else
  assign res      = shifted[OUT_W-1:0];   // two's-complement wrap
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      dct_out   <= '0;
      out_index <= '0;
    end else begin
      out_valid <= 1'b0;
      if (reset_MAC) begin
        // drop in-flight terms; a coincident strobe starts the new block
        vld_pipe <= {2'b00, active_MAC};
        acc      <= '0;
        cnt      <= '0;
      end else begin
        vld_pipe <= {vld_pipe[1:0], active_MAC};
        if (vld_pipe[2]) begin
          if (fire) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b1;
            dct_out   <= res;
            out_index <= tag_s2;
          end else begin
            acc <= sum;
            cnt <= cnt + 6'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dct_mac_unit.sv
// tb_dct_mac_unit: directed stimulus for dct_mac_unit at OUT_W=12 and OUT_W=10,
// checked every cycle against a real-arithmetic DCT model plus literal values.
// Honours DCT_MAC_SAT_EN for the expected narrowing behaviour.
module tb_dct_mac_unit;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       active_MAC = 1'b0, reset_MAC = 1'b0;
  logic [7:0] pixel_data = '0;
  logic [2:0] u = '0, v = '0, x = '0, y = '0;
  logic signed [11:0] dout12;
  logic signed [9:0]  dout10;
  logic       vld12, vld10, sat12, sat10;
  logic [5:0] idx12, idx10;

  always #5 clock = ~clock;

  dct_mac_unit #(.PIX_W(8), .OUT_W(12), .ACC_W(32)) dut12 (
    .clock(clock), .reset(reset), .active_MAC(active_MAC), .reset_MAC(reset_MAC),
    .pixel_data(pixel_data), .u(u), .v(v), .x(x), .y(y),
    .dct_out(dout12), .out_valid(vld12), .out_index(idx12), .sat_flag(sat12));

  dct_mac_unit #(.PIX_W(8), .OUT_W(10), .ACC_W(32)) dut10 (
    .clock(clock), .reset(reset), .active_MAC(active_MAC), .reset_MAC(reset_MAC),
    .pixel_data(pixel_data), .u(u), .v(v), .x(x), .y(y),
    .dct_out(dout10), .out_valid(vld10), .out_index(idx10), .sat_flag(sat10));

`ifdef DCT_MAC_SAT_EN
  localparam int EXP10 = 511;
  localparam int SATX  = 1;
`else
  localparam int EXP10 = -19;
  localparam int SATX  = 0;
`endif

  int n_cmp = 0, n_fail = 0, pulses = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int ctab [8][8];
  typedef struct { longint due; longint term; int idx; } pend_t;
  pend_t  q[$];
  longint m_acc, cyc;
  int     m_cnt;
  longint h12, h10;
  int     hidx;
  bit     ms12, ms10;

  function automatic longint narrow(input longint s, input int w, output bit hit);
    longint mx, mn, m;
    mx = (longint'(1) << (w-1)) - 1;
    mn = -mx - 1;
    hit = 1'b0;
    m = s;
`ifdef DCT_MAC_SAT_EN
    if (s > mx) begin hit = 1'b1; m = mx; end
    if (s < mn) begin hit = 1'b1; m = mn; end
`else
    m = s & ((longint'(1) << w) - 1);
    if (m > mx) m -= (longint'(1) << w);
`endif
    return m;
  endfunction

  task automatic model_clear();
    q.delete(); m_acc = 0; m_cnt = 0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++)
        ctab[k][n] = int'(64.0 * ((k == 0) ? 1.0/$sqrt(2.0) : 1.0) *
                          $cos((2.0*n + 1.0) * k * 3.14159265358979 / 16.0));
    model_clear(); cyc = 0; h12 = 0; h10 = 0; hidx = 0; ms12 = 0; ms10 = 0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        model_clear(); h12 = 0; h10 = 0; hidx = 0; ms12 = 0; ms10 = 0;
        #1;
        chk("rst_valid", vld12, 0); chk("rst_dout12", dout12, 0);
        chk("rst_idx", idx12, 0);   chk("rst_dout10", dout10, 0);
        chk("rst_sat10", sat10, 0);
      end else begin
        bit     ev, a, r, hit;
        longint t, s;
        pend_t  p;
        cyc++;
        ev = 0; a = active_MAC; r = reset_MAC;
        t = (longint'(pixel_data) - 128) * ctab[u][x] * ctab[v][y];
        if (r) model_clear();
        else if (q.size() > 0 && q[0].due == cyc) begin
          p = q.pop_front();
          m_acc += p.term; m_cnt++;
          if (m_cnt == 64) begin
            s = (m_acc + 8192) >>> 14;
            h12 = narrow(s, 12, hit); ms12 |= hit;
            h10 = narrow(s, 10, hit); ms10 |= hit;
            hidx = p.idx; ev = 1; m_acc = 0; m_cnt = 0;
          end
        end
        if (a) q.push_back('{cyc + 3, t, {u, v}});
        #1;
        if (vld12) pulses++;
        chk("valid12", vld12, ev); chk("valid10", vld10, ev);
        chk("dout12", dout12, h12); chk("dout10", dout10, h10);
        chk("idx12", idx12, hidx);  chk("idx10", idx10, hidx);
        chk("sat12", sat12, ms12);  chk("sat10", sat10, ms10);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_term(input int pix, input int uu, input int vv,
                            input int xx, input int yy, input bit rm);
    @(negedge clock);
    active_MAC = 1'b1; reset_MAC = rm; pixel_data = pix[7:0];
    u = uu[2:0]; v = vv[2:0]; x = xx[2:0]; y = yy[2:0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock); active_MAC = 1'b0; reset_MAC = 1'b0;
    end
  endtask

  // pmode >= 0: constant pixel; pmode < 0: varying pattern
  task automatic run_block(input int pmode, input int uu, input int vv);
    for (int i = 0; i < 64; i++)
      drive_term((pmode >= 0) ? pmode : ((i*37 + uu*11 + vv*5) & 255),
                 uu, vv, i / 8, i % 8, 1'b0);
  endtask

  initial begin
    int row2 [8];
    row2 = '{59, 24, -24, -59, -59, -24, 24, 59};
    #2 reset = 1'b0;
    #1;
    // pin the model's coefficient table
    chk("tab_c00", ctab[0][0], 45); chk("tab_c07", ctab[0][7], 45);
    for (int n = 0; n < 8; n++) chk("tab_c2n", ctab[2][n], row2[n]);
    chk("tab_c10", ctab[1][0], 63); chk("tab_c73", ctab[7][3], -63);
    #17;
    chk("reset_dout", dout12, 0); chk("reset_valid", vld12, 0);
    chk("reset_idx", idx12, 0);   chk("reset_sat", sat10, 0);
    @(negedge clock); reset = 1'b1;
    idle(2);

    run_block(255, 0, 0); idle(4);
    chk("dc255_12", dout12, 1005); chk("dc255_idx", idx12, 0);
    chk("dc255_10", dout10, EXP10); chk("dc255_sat10", sat10, SATX);
    chk("dc255_sat12", sat12, 0);

    run_block(255, 1, 2); idle(4);
    chk("ac12_dout", dout12, 0); chk("ac12_idx", idx12, 10);
    run_block(255, 7, 7); idle(4);
    chk("ac77_dout", dout12, 0); chk("ac77_idx", idx12, 63);

    run_block(0, 0, 0); idle(4);
    chk("dc0_dout", dout12, -1012);

    run_block(-1, 3, 5); run_block(-1, 0, 0); idle(4);

    // reset_MAC mid-block, coincident with a new block's first term
    for (int i = 0; i < 20; i++) drive_term(0, 2, 2, i / 8, i % 8, 1'b0);
    drive_term(255, 0, 0, 0, 0, 1'b1);
    for (int i = 1; i < 64; i++) drive_term(255, 0, 0, i / 8, i % 8, 1'b0);
    idle(4);
    chk("rmac_dout", dout12, 1005);

    // async reset mid-block
    run_block(0, 0, 0); idle(4);
    for (int i = 0; i < 30; i++) drive_term(255, 4, 1, i / 8, i % 8, 1'b0);
    @(posedge clock); #2;
    reset = 1'b0; active_MAC = 1'b0;
    #1;
    chk("arst_dout", dout12, 0); chk("arst_valid", vld12, 0);
    chk("arst_idx", idx12, 0);
    @(negedge clock); @(negedge clock); reset = 1'b1;
    idle(1);
    run_block(255, 0, 0); idle(4);
    chk("arst_after", dout12, 1005);

    // full FSM index sweep at pixel 128, back to back
    pulses = 0;
    for (int uv = 0; uv < 64; uv++) run_block(128, uv / 8, uv % 8);
    idle(5);
    chk("sweep_pulses", pulses, 64);
    chk("sweep_dout", dout12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
